// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register map, STATUS bit positions and FSM states for uart_fifo_periph
package uart_pkg;
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_BAUD   = 2'd3;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_TX_BUSY  = 4;
  localparam int ST_RX_OVR   = 5;
  localparam int ST_FRAME    = 6;
  localparam int ST_TX_OVF   = 7;
  localparam int ST_RX_CNT   = 8;
  localparam int ST_TX_CNT   = 16;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // A zero divisor would never tick; it behaves as a divisor of one.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO with show-ahead head, used for TX and RX queues
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop on a full FIFO frees the slot for a push in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_fifo_periph.sv
// rtl/uart_fifo_periph.sv - memory-mapped 8N1 UART with TX/RX FIFOs, baud divisor and interrupts
module uart_fifo_periph
  import uart_pkg::*;
#(
  parameter int TX_DEPTH   = 16,
  parameter int RX_DEPTH   = 16,
  parameter int BAUD_RESET = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  addrIn,
  input  logic [7:0]  addrOut,
  input  logic [3:0]  sizeDecode,
  input  logic [31:0] dataIn,
  input  logic        readEn,
  output logic [31:0] dataOut,
  output logic        IRQ,
  output logic        TXD,
  input  logic        RXD
);
  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;

  logic [3:0]  ctrl;
  logic [15:0] baud;
  logic [15:0] baud_cnt;
  logic        tick;
  logic        wr_data, wr_status, wr_ctrl, wr_baud;

  logic           tx_full, tx_empty, tx_pop;
  logic [TCW-1:0] tx_count;
  logic [7:0]     tx_head;
  logic           rx_full, rx_empty, rx_pop, rx_push;
  logic [RCW-1:0] rx_count;
  logic [7:0]     rx_head;

  tx_state_t   tx_state;
  logic [3:0]  tx_tick_cnt;
  logic [2:0]  tx_bit_idx;
  logic [7:0]  tx_shift;
  logic        tx_bit_end;
  logic        tx_busy;

  rx_state_t   rx_state;
  logic [3:0]  rx_tick_cnt;
  logic [2:0]  rx_bit_idx;
  logic [7:0]  rx_shift;
  logic        rxd_meta, rxd_sync, rxd_prev;
  logic        rx_fall, rx_stop_end, rx_frame_bad;

  logic        rx_overrun, frame_err, tx_overflow;
  logic [31:0] status;
  logic [31:0] rd_data;
  logic        unused_bits;

  assign unused_bits = ^{addrIn[7:4], addrIn[1:0], addrOut[7:4], addrOut[1:0], dataIn[31:16]};

  assign wr_data   = sizeDecode[0] && (addrIn[3:2] == REG_DATA);
  assign wr_status = sizeDecode[0] && (addrIn[3:2] == REG_STATUS);
  assign wr_ctrl   = sizeDecode[0] && (addrIn[3:2] == REG_CTRL);
  assign wr_baud   = (|sizeDecode) && (addrIn[3:2] == REG_BAUD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl <= 4'h3;
      baud <= 16'(BAUD_RESET);
    end else begin
      if (wr_ctrl) ctrl <= dataIn[3:0];
      if (wr_baud && sizeDecode[0]) baud[7:0]  <= dataIn[7:0];
      if (wr_baud && sizeDecode[1]) baud[15:8] <= dataIn[15:8];
    end
  end

  assign tick = (baud_cnt == eff_div(baud) - 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  baud_cnt <= '0;
    else if (wr_baud || tick) baud_cnt <= '0;
    else                      baud_cnt <= baud_cnt + 16'd1;
  end

  uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(wr_data), .push_data(dataIn[7:0]), .pop(tx_pop),
    .full(tx_full), .empty(tx_empty), .count(tx_count), .head(tx_head)
  );

  uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .push_data(rx_shift), .pop(rx_pop),
    .full(rx_full), .empty(rx_empty), .count(rx_count), .head(rx_head)
  );

  // Transmitter: a new byte is taken only from IDLE or at the end of a stop bit.
  assign tx_bit_end = tick && (tx_tick_cnt == 4'd15);
  assign tx_pop     = ctrl[0] && !tx_empty &&
                      ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_bit_end));
  assign tx_busy    = (tx_state != TX_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state    <= TX_IDLE;
      tx_tick_cnt <= '0;
      tx_bit_idx  <= '0;
      tx_shift    <= '0;
      TXD         <= 1'b1;
    end else begin
      if (tick && tx_state != TX_IDLE) tx_tick_cnt <= tx_tick_cnt + 4'd1;
      case (tx_state)
        TX_IDLE: if (tx_pop) begin
          tx_shift    <= tx_head;
          tx_tick_cnt <= '0;
          TXD         <= 1'b0;
          tx_state    <= TX_START;
        end
        TX_START: if (tx_bit_end) begin
          TXD        <= tx_shift[0];
          tx_bit_idx <= '0;
          tx_state   <= TX_DATA;
        end
        TX_DATA: if (tx_bit_end) begin
          if (tx_bit_idx == 3'd7) begin
            TXD      <= 1'b1;
            tx_state <= TX_STOP;
          end else begin
            tx_shift   <= {1'b0, tx_shift[7:1]};
            TXD        <= tx_shift[1];
            tx_bit_idx <= tx_bit_idx + 3'd1;
          end
        end
        TX_STOP: if (tx_bit_end) begin
          if (tx_pop) begin
            tx_shift <= tx_head;
            TXD      <= 1'b0;
            tx_state <= TX_START;
          end else begin
            tx_state <= TX_IDLE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= RXD;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  assign rx_fall      = rxd_prev && !rxd_sync;
  assign rx_stop_end  = (rx_state == RX_STOP) && tick && (rx_tick_cnt == 4'd15);
  assign rx_push      = rx_stop_end && rxd_sync;
  assign rx_frame_bad = rx_stop_end && !rxd_sync;
  assign rx_pop       = readEn && (addrOut[3:2] == REG_DATA) && !rx_empty;

  // Receiver: start bit is re-checked at its middle, later samples land mid-bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state    <= RX_IDLE;
      rx_tick_cnt <= '0;
      rx_bit_idx  <= '0;
      rx_shift    <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: if (ctrl[1] && rx_fall) begin
          rx_tick_cnt <= '0;
          rx_state    <= RX_START;
        end
        RX_START: if (tick) begin
          if (rx_tick_cnt == 4'd7) begin
            rx_tick_cnt <= '0;
            rx_bit_idx  <= '0;
            rx_state    <= rxd_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_tick_cnt <= rx_tick_cnt + 4'd1;
          end
        end
        RX_DATA: if (tick) begin
          rx_tick_cnt <= rx_tick_cnt + 4'd1;
          if (rx_tick_cnt == 4'd15) begin
            rx_shift   <= {rxd_sync, rx_shift[7:1]};
            rx_bit_idx <= rx_bit_idx + 3'd1;
            if (rx_bit_idx == 3'd7) rx_state <= RX_STOP;
          end
        end
        RX_STOP: if (tick) begin
          rx_tick_cnt <= rx_tick_cnt + 4'd1;
          if (rx_tick_cnt == 4'd15) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // A W1C write loses against a new error event in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_overrun  <= 1'b0;
      frame_err   <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      rx_overrun  <= (rx_overrun && !(wr_status && dataIn[ST_RX_OVR])) ||
                     (rx_push && rx_full && !rx_pop);
      frame_err   <= (frame_err && !(wr_status && dataIn[ST_FRAME])) || rx_frame_bad;
      tx_overflow <= (tx_overflow && !(wr_status && dataIn[ST_TX_OVF])) ||
                     (wr_data && tx_full && !tx_pop);
    end
  end

  always_comb begin
    status = '0;
    status[ST_TX_FULL]  = tx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_TX_BUSY]  = tx_busy;
    status[ST_RX_OVR]   = rx_overrun;
    status[ST_FRAME]    = frame_err;
    status[ST_TX_OVF]   = tx_overflow;
    status[ST_RX_CNT +: 8] = 8'(rx_count);
    status[ST_TX_CNT +: 8] = 8'(tx_count);
    rd_data = '0;
    case (addrOut[3:2])
      REG_DATA:   if (!rx_empty) rd_data[7:0] = rx_head;
      REG_STATUS: rd_data = status;
      REG_CTRL:   rd_data[3:0] = ctrl;
      REG_BAUD:   rd_data[15:0] = baud;
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dataOut <= '0;
      IRQ     <= 1'b0;
    end else begin
      dataOut <= rd_data;
      IRQ     <= (ctrl[2] && !rx_empty) || (ctrl[3] && tx_empty && !tx_busy);
    end
  end
endmodule

// File: tb/tb_uart_fifo_periph.sv
// tb/tb_uart_fifo_periph.sv - self-checking bench for uart_fifo_periph against a queue-based model
module tb_uart_fifo_periph;
  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam logic [1:0] A_BAUD   = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  addrIn, addrOut;
  logic [3:0]  sizeDecode;
  logic [31:0] dataIn;
  logic        readEn;
  logic [31:0] dataOut;
  logic        IRQ, TXD, RXD;
  logic        loop, rxd_drv;

  int total = 0;
  int bad   = 0;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic m_ovr, m_fe, m_txo;

  assign RXD = loop ? TXD : rxd_drv;
  always #5 clk = ~clk;

  uart_fifo_periph #(.TX_DEPTH(16), .RX_DEPTH(16), .BAUD_RESET(27)) dut (
    .clk(clk), .rst(rst), .addrIn(addrIn), .addrOut(addrOut), .sizeDecode(sizeDecode),
    .dataIn(dataIn), .readEn(readEn), .dataOut(dataOut), .IRQ(IRQ), .TXD(TXD), .RXD(RXD)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input int ntx, input int nrx, input logic busy,
                                             input logic ovr, input logic fe, input logic txo);
    return {8'd0, 8'(ntx), 8'(nrx), txo, fe, ovr, busy, nrx == 16, nrx == 0, ntx == 0, ntx == 16};
  endfunction

  task automatic bus_write(input logic [1:0] idx, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    addrIn = {4'd0, idx, 2'd0};
    dataIn = d;
    sizeDecode = be;
    @(negedge clk);
    sizeDecode = 4'd0;
  endtask

  task automatic bus_read(input logic [1:0] idx, output logic [31:0] d);
    @(negedge clk);
    addrOut = {4'd0, idx, 2'd0};
    readEn = 1'b1;
    @(negedge clk);
    readEn = 1'b0;
    d = dataOut;
  endtask

  task automatic wait_tx_idle(input int budget);
    logic [31:0] s;
    int n;
    n = 0;
    do begin
      bus_read(A_STATUS, s);
      n++;
    end while (!(s[1] && !s[4]) && n < budget);
    check("tx_idle_wait", {31'd0, s[1] && !s[4]}, 32'd1);
  endtask

  task automatic check_status(input string tag);
    logic [31:0] s;
    bus_read(A_STATUS, s);
    check(tag, s, exp_status(txq.size(), rxq.size(), 1'b0, m_ovr, m_fe, m_txo));
  endtask

  // Serial frame seen on TXD: 16 clocks per bit at BAUD=1, busy for the whole frame.
  task automatic tx_frame_check(input logic [7:0] b, input string tag);
    logic [15:0] win;
    logic [9:0]  bits;
    int busy_low;
    int n;
    bits = {1'b1, b, 1'b0};
    busy_low = 0;
    n = 0;
    bus_write(A_DATA, {24'd0, b}, 4'b0001);
    addrOut = {4'd0, A_STATUS, 2'd0};
    readEn = 1'b0;
    while (TXD !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_start_seen"}, {31'd0, TXD}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 16; j++) begin
        win[j] = TXD;
        if ((k != 0 || j != 0) && dataOut[4] !== 1'b1) busy_low++;
        @(negedge clk);
      end
      check($sformatf("%s_bit%0d", tag, k), {16'd0, win}, {16'd0, {16{bits[k]}}});
    end
    check({tag, "_busy"}, 32'(busy_low), 32'd0);
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_drv = bits[i];
      repeat (16) @(negedge clk);
    end
    rxd_drv = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  b;
    int n;
    rst = 1'b1; loop = 1'b0; rxd_drv = 1'b1;
    addrIn = '0; addrOut = '0; sizeDecode = '0; dataIn = '0; readEn = 1'b0;
    m_ovr = 1'b0; m_fe = 1'b0; m_txo = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dataOut", dataOut, 32'd0);
    check("rst_txd", {31'd0, TXD}, 32'd1);
    check("rst_irq", {31'd0, IRQ}, 32'd0);
    rst = 1'b0;
    check_status("rst_status");
    bus_read(A_CTRL, r);  check("rst_ctrl", r, 32'h3);
    bus_read(A_BAUD, r);  check("rst_baud", r, 32'd27);

    bus_write(A_BAUD, 32'h0000_0001, 4'b0011);
    bus_read(A_BAUD, r);  check("baud_wr", r, 32'd1);
    tx_frame_check(8'hA5, "tx_a5");
    tx_frame_check(8'($urandom), "tx_rnd");
    check_status("tx_done_status");

    bus_write(A_CTRL, 32'h2, 4'b0001);
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      bus_write(A_DATA, {24'd0, b}, 4'b0001);
      if (txq.size() < 16) txq.push_back(b);
      else m_txo = 1'b1;
    end
    check_status("tx_overflow_status");
    bus_write(A_STATUS, 32'h80, 4'b0001);
    m_txo = 1'b0;
    check_status("tx_overflow_w1c");

    loop = 1'b1;
    bus_write(A_CTRL, 32'h3, 4'b0001);
    wait_tx_idle(2000);
    while (txq.size() > 0) begin
      b = txq.pop_front();
      if (rxq.size() < 16) rxq.push_back(b);
      else m_ovr = 1'b1;
    end
    check_status("rx_full_status");
    b = 8'($urandom);
    bus_write(A_DATA, {24'd0, b}, 4'b0001);
    wait_tx_idle(400);
    if (rxq.size() < 16) rxq.push_back(b);
    else m_ovr = 1'b1;
    check_status("rx_overrun_status");
    for (int i = 0; i < 16; i++) begin
      bus_read(A_DATA, r);
      check($sformatf("rx_order%0d", i), r, {24'd0, rxq.pop_front()});
    end
    check_status("rx_drained_status");
    bus_read(A_DATA, r);  check("rx_empty_read", r, 32'd0);
    bus_write(A_STATUS, 32'h20, 4'b0001);
    m_ovr = 1'b0;
    check_status("rx_overrun_w1c");

    bus_write(A_CTRL, 32'h7, 4'b0001);
    @(negedge clk);
    check("irq_idle", {31'd0, IRQ}, 32'd0);
    bus_write(A_DATA, 32'h3C, 4'b0001);
    n = 0;
    while (IRQ !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("irq_rise", {31'd0, IRQ}, 32'd1);
    wait_tx_idle(200);
    rxq.push_back(8'h3C);
    check_status("irq_rx_status");
    bus_read(A_DATA, r);
    check("irq_rx_data", r, {24'd0, rxq.pop_front()});
    @(negedge clk);
    check("irq_fall", {31'd0, IRQ}, 32'd0);
    check_status("irq_after_read");
    bus_write(A_CTRL, 32'hB, 4'b0001);
    @(negedge clk);
    check("irq_txdone", {31'd0, IRQ}, 32'd1);
    bus_write(A_CTRL, 32'h3, 4'b0001);
    @(negedge clk);
    check("irq_masked", {31'd0, IRQ}, 32'd0);

    loop = 1'b0;
    bus_write(A_CTRL, 32'h2, 4'b0001);
    rxd_drv = 1'b0;
    repeat (4) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (40) @(negedge clk);
    check_status("false_start");
    drive_frame(8'h55, 1'b0);
    m_fe = 1'b1;
    check_status("frame_err");
    bus_write(A_STATUS, 32'h40, 4'b0001);
    m_fe = 1'b0;
    check_status("frame_err_w1c");
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      drive_frame(b, 1'b1);
      rxq.push_back(b);
    end
    check_status("rx_rnd_status");
    for (int i = 0; i < 3; i++) begin
      bus_read(A_DATA, r);
      check($sformatf("rx_rnd%0d", i), r, {24'd0, rxq.pop_front()});
    end

    bus_write(A_CTRL, 32'h3, 4'b0001);
    bus_write(A_DATA, 32'h00, 4'b0001);
    n = 0;
    while (TXD !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    check("midframe_low", {31'd0, TXD}, 32'd0);
    rst = 1'b1;
    #1;
    check("midframe_rst_txd", {31'd0, TXD}, 32'd1);
    check("midframe_rst_dout", dataOut, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_status("post_rst_status");
    bus_read(A_BAUD, r);  check("post_rst_baud", r, 32'd27);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
